// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between the fetch port and the
// load/store port. Data wins by default; a starvation counter forces fetch through.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [StW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;  // 1 = data port, 0 = fetch port
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic starved;
    logic if_win;
    logic d_win;
    logic in_access;

    // Grants are gated by reset so every output reads 0 while reset is held.
    assign starved   = (starve_cnt_q == StW'(STARVE_MAX));
    assign if_win    = reset && (state_q == StIdle) && if_req && (!d_req || starved);
    assign d_win     = reset && (state_q == StIdle) && d_req && !(if_req && starved);
    assign in_access = (state_q == StAccess);

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_win) begin
                    state_d   = StAccess;
                    lat_cnt_d = LatW'(MEM_LAT - 1);
                    owner_d   = 1'b1;
                    addr_d    = d_addr;
                    wdata_d   = d_wdata;
                    we_d      = d_we;
                    if (if_req) begin
                        starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + StW'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (if_win) begin
                    state_d      = StAccess;
                    lat_cnt_d    = LatW'(MEM_LAT - 1);
                    owner_d      = 1'b0;
                    addr_d       = if_addr;
                    wdata_d      = '0;
                    we_d         = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            StAccess: begin
                if (lat_cnt_q == '0) begin
                    state_d = StResp;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign if_rvalid = (state_q == StResp) && !owner_q;
    assign d_rvalid  = (state_q == StResp) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance u_dut uses MEM_LAT=2, u_dut1 uses MEM_LAT=1.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00A00093 : {16'h5A5A, a[15:0]};
    endfunction

    assign mem_rdata   = mem_en ? mem_f(mem_addr) : 32'hBAD0BAD0;
    assign b_mem_rdata = b_mem_en ? mem_f(b_mem_addr) : 32'hBAD0BAD0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b1; b_d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h40;
        #2;
        n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 0000000",
                {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}); end
        n_cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h %h want 0",
                mem_addr, mem_wdata, if_rdata, d_rdata); end
        n_cmp++; if ({b_d_gnt, b_busy, b_mem_en} !== 3'b0) begin
            n_err++; $display("FAIL reset_dut1: got %b want 000", {b_d_gnt, b_busy, b_mem_en}); end
        if_req = 1'b0; d_req = 1'b0; b_d_req = 1'b0;
        next_cyc();
        reset = 1'b1;
        next_cyc();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        n_cmp++; if ({if_gnt, d_gnt, busy} !== 3'b100) begin
            n_err++; $display("FAIL fetch_gnt: got %b want 100", {if_gnt, d_gnt, busy}); end
        next_cyc();
        if_req = 1'b0; if_addr = 32'hFFFF;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_cmp++; if ({mem_en, mem_we, busy, mem_addr} !== {3'b101, 32'h100}) begin
                n_err++; $display("FAIL fetch_access%0d: got en/we/busy %b addr %h want 101 100",
                    c, {mem_en, mem_we, busy}, mem_addr); end
            next_cyc();
        end
        #1;
        n_cmp++; if ({if_rvalid, mem_en, busy, if_rdata} !== {3'b101, 32'h00A00093}) begin
            n_err++; $display("FAIL fetch_resp: got rv/en/busy %b data %h want 101 00a00093",
                {if_rvalid, mem_en, busy}, if_rdata); end
        next_cyc();
        #1;
        n_cmp++; if ({if_rvalid, busy, if_rdata} !== {2'b00, 32'h00A00093}) begin
            n_err++; $display("FAIL fetch_idle: got %b %h want 00 00a00093",
                {if_rvalid, busy}, if_rdata); end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL load_gnt: got %b want 1", d_gnt); end
        next_cyc();
        d_req = 1'b0;
        repeat (2) next_cyc();
        #1;
        n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h5A5A0040}) begin
            n_err++; $display("FAIL load_resp: got %b %h want 1 5a5a0040", d_rvalid, d_rdata); end
        next_cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL store_gnt: got %b want 1", d_gnt); end
        next_cyc();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hDEADBEEF}) begin
                n_err++; $display("FAIL store_access%0d: got %b %h %h want 11 20 deadbeef",
                    c, {mem_en, mem_we}, mem_addr, mem_wdata); end
            next_cyc();
        end
        #1;
        n_cmp++; if ({d_rvalid, mem_we, d_rdata} !== {2'b10, 32'h5A5A0040}) begin
            n_err++; $display("FAIL store_resp: got %b %h want 10 5a5a0040",
                {d_rvalid, mem_we}, d_rdata); end
        next_cyc();
        #1;
        n_cmp++; if (d_rvalid !== 1'b0) begin
            n_err++; $display("FAIL store_pulse: got %b want 0", d_rvalid); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) d_req = 1'b0;
            #1;
            n_cmp++; if ({if_gnt, d_gnt} !== ((c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL prio_c%0d: got if/d %b want %b", c, {if_gnt, d_gnt},
                    ((c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00)); end
            next_cyc();
        end
        if_req = 1'b0;
        repeat (2) next_cyc();
        #1;
        n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h5A5A0200}) begin
            n_err++; $display("FAIL prio_fetch_data: got %b %h want 1 5a5a0200", if_rvalid, if_rdata); end
        next_cyc();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_d = 10'b0111101111;  // bit i = 1 when grant i goes to data
        int idx = 0;
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (if_gnt && d_gnt) begin
                n_cmp++; n_err++; $display("FAIL starve_both_gnt: got 11 at cycle %0d want one-hot", c);
            end else if (if_gnt || d_gnt) begin
                n_cmp++;
                if (idx >= 10 || d_gnt !== exp_d[idx] || c != idx * 4) begin
                    n_err++; $display("FAIL starve_grant%0d: got d_gnt=%b at cycle %0d want %b at %0d",
                        idx, d_gnt, c, (idx < 10) ? exp_d[idx] : 1'b0, idx * 4); end
                idx++;
            end
            next_cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        n_cmp++; if (idx != 10) begin
            n_err++; $display("FAIL starve_count: got %0d grants want 10", idx); end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_load_gnt: got %b want 1", d_gnt); end
        next_cyc();
        d_req = 1'b0;
        next_cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
                     {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_err++; $display("FAIL rst_mid_outputs: got %b %h %h %h %h want all 0",
                {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy},
                mem_addr, mem_wdata, if_rdata, d_rdata); end
        repeat (2) next_cyc();
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        #1;
        n_cmp++; if ({if_gnt, d_gnt} !== 2'b10) begin
            n_err++; $display("FAIL rst_first_gnt: got %b want 10", {if_gnt, d_gnt}); end
        next_cyc();
        if_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_cmp++; if ({d_rvalid, if_rvalid} !== ((c == 3) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL rst_after_c%0d: got d/if rvalid %b want %b", c,
                    {d_rvalid, if_rvalid}, ((c == 3) ? 2'b01 : 2'b00)); end
            next_cyc();
        end
    endtask

    task automatic test_back_to_back();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h4;
        #1;
        n_cmp++; if (b_d_gnt !== 1'b1) begin
            n_err++; $display("FAIL b2b_gnt0: got %b want 1", b_d_gnt); end
        next_cyc();
        b_d_addr = 32'h8;
        #1;
        n_cmp++; if ({b_mem_en, b_d_gnt, b_mem_addr} !== {2'b10, 32'h4}) begin
            n_err++; $display("FAIL b2b_access0: got %b %h want 10 4", {b_mem_en, b_d_gnt}, b_mem_addr); end
        next_cyc();
        #1;
        n_cmp++; if ({b_d_rvalid, b_mem_en, b_d_gnt, b_d_rdata} !== {3'b100, 32'h5A5A0004}) begin
            n_err++; $display("FAIL b2b_resp0: got %b %h want 100 5a5a0004",
                {b_d_rvalid, b_mem_en, b_d_gnt}, b_d_rdata); end
        next_cyc();
        #1;
        n_cmp++; if ({b_d_gnt, b_d_rvalid} !== 2'b10) begin
            n_err++; $display("FAIL b2b_gnt1: got %b want 10", {b_d_gnt, b_d_rvalid}); end
        next_cyc();
        b_d_req = 1'b0;
        #1;
        n_cmp++; if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h8}) begin
            n_err++; $display("FAIL b2b_access1: got %b %h want 1 8", b_mem_en, b_mem_addr); end
        next_cyc();
        #1;
        n_cmp++; if ({b_d_rvalid, b_mem_en, b_d_rdata} !== {2'b10, 32'h5A5A0008}) begin
            n_err++; $display("FAIL b2b_resp1: got %b %h want 10 5a5a0008",
                {b_d_rvalid, b_mem_en}, b_d_rdata); end
        next_cyc();
        #1;
        n_cmp++; if ({b_d_rvalid, b_busy} !== 2'b00) begin
            n_err++; $display("FAIL b2b_idle: got %b want 00", {b_d_rvalid, b_busy}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        next_cyc();
        test_store();
        next_cyc();
        test_priority();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch port (read-only) and the load/store data port of the RISC core.
- Sits between the core datapath and the memory macro.
- Serialises accesses with a req/gnt/rvalid handshake and fixed data-over-fetch priority.
- Includes a starvation guard so fetch always makes progress.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LAT, 2, memory access cycles from first mem_en cycle to mem_rdata valid (>=1).
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse, if_rdata valid.
- if_rdata  output  DATA_W  fetch read data.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  one-cycle completion pulse (load data valid / store done).
- d_rdata  output  DATA_W  load read data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid in last ACCESS cycle.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, lat_cnt=0, starve_cnt=0.
  - All outputs 0, including rdata registers and latched address/data/we/owner.
  - Reset asserted mid-ACCESS or mid-RESP abandons the access; no rvalid follows.
- IDLE arbitration (gnt is combinational, one cycle only):
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both, starve_cnt<STARVE_MAX: d_gnt=1.
  - Both, starve_cnt==STARVE_MAX: if_gnt=1.
  - Never both gnts high in the same cycle.
- On the clock edge ending a grant cycle:
  - Latch the winner's addr and wdata into registers; latch we (d_we for data, 0 for fetch); latch owner.
  - lat_cnt<=MEM_LAT-1; state<=ACCESS.
- Requester handshake:
  - Must hold req/addr/we/wdata stable until the cycle it sees gnt.
  - May drop or change them afterwards.
  - A req raised during ACCESS or RESP waits; no gnt outside IDLE.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched registers, constant for all MEM_LAT cycles.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0: capture mem_rdata into the owner's rdata register (loads/fetches only), state<=RESP.
- RESP:
  - Owner's rvalid=1 for exactly one cycle; mem_en=0; state<=IDLE.
  - Stores: d_rvalid pulses and d_rdata keeps its previous value.
  - rdata registers hold their value until the next read completion for that port.
- Outside ACCESS: mem_en, mem_we, mem_addr, mem_wdata are all 0.
- Throughput: one access per MEM_LAT+2 cycles; grant-to-rvalid latency = MEM_LAT+1 cycles.
- starve_cnt, updated at grant edges only:
  - Data grant while if_req=1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear to 0.
  - Data grant with if_req=0: clear to 0.
- busy=1 in ACCESS and RESP, 0 in IDLE.

Test Plan:
- MEM_LAT=2, if_req with if_addr=0x100, memory returns 0x00A00093:
  - if_gnt in cycle 0; mem_en in cycles 1-2 with mem_addr=0x100, mem_we=0.
  - if_rvalid in cycle 3 with if_rdata=0x00A00093; busy high in cycles 1-3.
- Store with d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF:
  - mem_we=1 and mem_wdata=0xDEADBEEF in both ACCESS cycles.
  - d_rvalid pulses in cycle 3; d_rdata unchanged.
- if_req and d_req both high from cycle 0, starve_cnt=0:
  - d_gnt in cycle 0; if_gnt in cycle 4 (next IDLE).
  - Never both gnts high in the same cycle.
- STARVE_MAX=4, d_req and if_req held continuously:
  - Grant sequence is D,D,D,D,F,D,D,D,D,F, with grants spaced MEM_LAT+2=4 cycles apart.
- Reset driven low during the second ACCESS cycle of a load:
  - All outputs 0 immediately (asynchronous); no d_rvalid afterwards.
  - After release, a new if_req is granted in the first IDLE cycle.
- MEM_LAT=1, back-to-back loads to 0x4 and 0x8:
  - Each load has 1 mem_en cycle; second gnt arrives 3 cycles after the first.
  - d_rdata values appear in order, each with a single d_rvalid pulse.
